// File: rtl/lcd_stream_timing_gen_if.sv
// Queue-side handshake between the camera frame queue (slave) and the LCD
// timing generator (master), which pops first-word-fall-through head words.
interface lcd_stream_timing_gen_if #(
  parameter int PIXEL_W = 16
);
  logic [PIXEL_W:0] queue_data_in;
  logic             queue_empty;
  logic             queue_rd_en;

  modport master (input queue_data_in, input queue_empty, output queue_rd_en);
  modport slave  (output queue_data_in, output queue_empty, input queue_rd_en);
endinterface

// File: rtl/lcd_stream_timing_gen.sv
// Free-running HSYNC/VSYNC/DE timing for an RGB LCD, fed from a marker-tagged
// pixel queue; underflow shows FILL_COLOR and FS markers re-align the stream.
module lcd_stream_timing_gen #(
  parameter int                H_ACTIVE   = 480,
  parameter int                H_SYNC     = 4,
  parameter int                H_BP       = 43,
  parameter int                H_FP       = 4,
  parameter int                V_ACTIVE   = 272,
  parameter int                V_SYNC     = 3,
  parameter int                V_BP       = 12,
  parameter int                V_FP       = 4,
  parameter bit                HS_POL     = 1'b1,
  parameter bit                VS_POL     = 1'b1,
  parameter int                PIXEL_W    = 16,
  parameter logic [PIXEL_W-1:0] FILL_COLOR = '0,
  localparam int               R_W        = (PIXEL_W == 24) ? 8 : 5,
  localparam int               G_W        = (PIXEL_W == 24) ? 8 : 6,
  localparam int               B_W        = (PIXEL_W == 24) ? 8 : 5
) (
  input  logic                    clk,
  input  logic                    reset,
  lcd_stream_timing_gen_if.master q,
  output logic                    queue_clk,
  output logic                    LCD_DE,
  output logic                    LCD_HSYNC,
  output logic                    LCD_VSYNC,
  output logic [R_W-1:0]          LCD_R,
  output logic [G_W-1:0]          LCD_G,
  output logic [B_W-1:0]          LCD_B,
  output logic [15:0]             underflow_count,
  output logic                    resync
);
  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST      = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_SYNC_END  = HW'(H_SYNC);
  localparam logic [HW-1:0] H_ACT_START = HW'(H_SYNC + H_BP);
  localparam logic [HW-1:0] H_ACT_END   = HW'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [HW-1:0] H_ACT_LAST  = HW'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam logic [VW-1:0] V_LAST      = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_SYNC_END  = VW'(V_SYNC);
  localparam logic [VW-1:0] V_ACT_START = VW'(V_SYNC + V_BP);
  localparam logic [VW-1:0] V_ACT_END   = VW'(V_SYNC + V_BP + V_ACTIVE);

  localparam logic [PIXEL_W-1:0] MARK_FS = '0;
  localparam logic [PIXEL_W-1:0] MARK_RS = PIXEL_W'(1);
  localparam logic [PIXEL_W-1:0] MARK_FE = '1;

  typedef enum logic [2:0] {SEEK_FRAME, ARMED, ROW_WAIT, LINE, DRAIN} state_t;

  state_t               state;
  logic [HW-1:0]        h;
  logic [VW-1:0]        v;
  logic                 hs, vs, act, last_act;
  logic                 is_marker, is_fs, is_rs, is_fe, have_pixel, pop;
  logic [PIXEL_W-1:0]   payload, pixel;

  assign queue_clk = clk;

  assign hs       = (h < H_SYNC_END);
  assign vs       = (v < V_SYNC_END);
  assign act      = (h >= H_ACT_START) && (h < H_ACT_END) &&
                    (v >= V_ACT_START) && (v < V_ACT_END);
  assign last_act = act && (h == H_ACT_LAST);

  assign payload    = q.queue_data_in[PIXEL_W-1:0];
  assign is_marker  = !q.queue_empty && q.queue_data_in[PIXEL_W];
  assign is_fs      = is_marker && (payload == MARK_FS);
  assign is_rs      = is_marker && (payload == MARK_RS);
  assign is_fe      = is_marker && (payload == MARK_FE);
  assign have_pixel = !q.queue_empty && !q.queue_data_in[PIXEL_W];

  // An FS met outside SEEK_FRAME is consumed on the resync so ARMED always
  // means "frame start taken, waiting for the raster origin".
  always_comb begin
    // NOTE: default first so every path assigns pop and no latch is inferred.
    pop = 1'b0;
    case (state)
      SEEK_FRAME: pop = !q.queue_empty;
      ROW_WAIT:   pop = !q.queue_empty;
      LINE:       pop = (act && have_pixel) || is_fs;
      DRAIN:      pop = have_pixel || is_fs;
      default:    pop = 1'b0;
    endcase
  end

  // Gating with reset keeps the queue intact on the edge that resets us.
  assign q.queue_rd_en = pop && !reset;

  assign pixel = (state == LINE && act && have_pixel) ? payload : FILL_COLOR;

  always_ff @(posedge clk) begin
    if (reset) begin
      h               <= '0;
      v               <= '0;
      state           <= SEEK_FRAME;
      LCD_DE          <= 1'b0;
      LCD_HSYNC       <= !HS_POL;
      LCD_VSYNC       <= !VS_POL;
      LCD_R           <= '0;
      LCD_G           <= '0;
      LCD_B           <= '0;
      underflow_count <= '0;
      resync          <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // right-hand side sees the pre-edge values.
      h <= (h == H_LAST) ? '0 : h + 1'b1;
      if (h == H_LAST) v <= (v == V_LAST) ? '0 : v + 1'b1;

      LCD_HSYNC <= hs ? HS_POL : !HS_POL;
      LCD_VSYNC <= vs ? VS_POL : !VS_POL;
      LCD_DE    <= act;
      LCD_R     <= act ? pixel[PIXEL_W-1 -: R_W] : '0;
      LCD_G     <= act ? pixel[B_W +: G_W]       : '0;
      LCD_B     <= act ? pixel[0 +: B_W]         : '0;

      if (state == LINE && act && !have_pixel && underflow_count != 16'hFFFF)
        underflow_count <= underflow_count + 16'd1;

      resync <= 1'b0;
      case (state)
        SEEK_FRAME: if (is_fs) state <= ARMED;
        ARMED:      if (h == '0 && v == '0) state <= ROW_WAIT;
        ROW_WAIT: begin
          if (is_fs) begin
            resync <= 1'b1;
            state  <= ARMED;
          end else if (is_rs) state <= LINE;
          else if (is_fe)     state <= SEEK_FRAME;
        end
        LINE: begin
          if (is_fs) begin
            resync <= 1'b1;
            state  <= ARMED;
          end else if (last_act) state <= DRAIN;
        end
        DRAIN: begin
          if (is_fs) begin
            resync <= 1'b1;
            state  <= ARMED;
          end else if (is_marker) state <= ROW_WAIT;
        end
        default: state <= SEEK_FRAME;
      endcase
    end
  end
endmodule

// File: tb/tb_lcd_stream_timing_gen.sv
// Randomised stream bench: two small-raster instances (RGB565 positive sync,
// RGB888 negative sync) checked cycle by cycle against raster arithmetic.
module tb_lcd_stream_timing_gen;
  localparam int HT = 14, VT = 10, FRAME = HT * VT, MAXC = 4 * FRAME;
  localparam int H0 = 4, V0 = 4, HA = 8, VA = 4;
  localparam logic [15:0] FILL0 = 16'hF81F;
  localparam logic [23:0] FILL1 = 24'h123456;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // instance 0: RGB565, active-high sync
  logic rst0 = 1'b1;
  lcd_stream_timing_gen_if #(.PIXEL_W(16)) qi0 ();
  logic de0, hs0, vs0, qclk0, rsy0;
  logic [4:0] r0, b0;
  logic [5:0] g0;
  logic [15:0] uf0;

  // instance 1: RGB888, active-low sync
  logic rst1 = 1'b1;
  lcd_stream_timing_gen_if #(.PIXEL_W(24)) qi1 ();
  logic de1, hs1, vs1, qclk1, rsy1;
  logic [7:0] r1, g1, b1;
  logic [15:0] uf1;

  lcd_stream_timing_gen #(
    .H_ACTIVE(8), .H_SYNC(2), .H_BP(2), .H_FP(2),
    .V_ACTIVE(4), .V_SYNC(2), .V_BP(2), .V_FP(2),
    .HS_POL(1'b1), .VS_POL(1'b1), .PIXEL_W(16), .FILL_COLOR(FILL0)
  ) dut0 (
    .clk(clk), .reset(rst0), .q(qi0), .queue_clk(qclk0),
    .LCD_DE(de0), .LCD_HSYNC(hs0), .LCD_VSYNC(vs0),
    .LCD_R(r0), .LCD_G(g0), .LCD_B(b0),
    .underflow_count(uf0), .resync(rsy0)
  );

  lcd_stream_timing_gen #(
    .H_ACTIVE(8), .H_SYNC(2), .H_BP(2), .H_FP(2),
    .V_ACTIVE(4), .V_SYNC(2), .V_BP(2), .V_FP(2),
    .HS_POL(1'b0), .VS_POL(1'b0), .PIXEL_W(24), .FILL_COLOR(FILL1)
  ) dut1 (
    .clk(clk), .reset(rst1), .q(qi1), .queue_clk(qclk1),
    .LCD_DE(de1), .LCD_HSYNC(hs1), .LCD_VSYNC(vs1),
    .LCD_R(r1), .LCD_G(g1), .LCD_B(b1),
    .underflow_count(uf1), .resync(rsy1)
  );

  // queue models, pixel sets and observations
  logic [16:0] q0[$];
  logic [24:0] q1[$];
  logic [23:0] pix_set[8][$];
  int stall_lo = -1, stall_hi = -1;
  logic [15:0] exp0[MAXC];
  logic [23:0] exp1[MAXC];
  logic        de_obs[MAXC], hs_obs[MAXC], vs_obs[MAXC];
  logic [23:0] px_obs[MAXC];
  int          resync_cnt;

  // ---------------- reference model ----------------
  function automatic bit act_at(input int n);
    int h = n % HT;
    int v = (n / HT) % VT;
    return (h >= H0) && (h < H0 + HA) && (v >= V0) && (v < V0 + VA);
  endfunction

  function automatic bit hs_at(input int n);
    return (n % HT) < 2;
  endfunction

  function automatic bit vs_at(input int n);
    return ((n / HT) % VT) < 2;
  endfunction

  function automatic int slot(input int frame, input int line, input int col);
    return frame * FRAME + (V0 + line) * HT + H0 + col;
  endfunction

  // Each act slot of a line shows the next queued pixel unless the queue is
  // empty in that slot or the line has run out of pixels.
  task automatic place(input int base, input int frame, input int line, input bit wide);
    int k = 0;
    logic [23:0] w;
    for (int c = 0; c < HA; c++) begin
      int n = slot(frame, line, c);
      if (n >= stall_lo && n <= stall_hi) begin
        exp0[n] = FILL0;
        exp1[n] = FILL1;
      end else if (k < pix_set[base + line].size()) begin
        w = pix_set[base + line][k];
        if (wide) exp1[n] = w; else exp0[n] = w[15:0];
        k++;
      end
    end
  endtask

  task automatic clear_exp();
    for (int n = 0; n < MAXC; n++) begin
      exp0[n] = FILL0;
      exp1[n] = FILL1;
    end
  endtask

  task automatic gen_set(input int base, input int len1);
    for (int l = 0; l < VA; l++) begin
      pix_set[base + l].delete();
      for (int k = 0; k < ((l == 1) ? len1 : HA); k++)
        pix_set[base + l].push_back(24'($urandom));
    end
  endtask

  task automatic push_lines0(input int base, input int first, input int last);
    logic [23:0] w;
    for (int l = first; l <= last; l++) begin
      q0.push_back({1'b1, 16'h0001});
      for (int k = 0; k < pix_set[base + l].size(); k++) begin
        w = pix_set[base + l][k];
        q0.push_back({1'b0, w[15:0]});
      end
    end
  endtask

  // ---------------- queue drivers and run loops ----------------
  task automatic drive0(input int n);
    qi0.queue_empty   = (q0.size() == 0) || (n >= stall_lo && n <= stall_hi);
    qi0.queue_data_in = (q0.size() != 0) ? q0[0] : 17'h0;
  endtask

  task automatic drive1();
    qi1.queue_empty   = (q1.size() == 0);
    qi1.queue_data_in = (q1.size() != 0) ? q1[0] : 25'h0;
  endtask

  task automatic reset0();
    rst0 = 1'b1;
    drive0(0);
    repeat (2) @(posedge clk);
    #1 rst0 = 1'b0;
    drive0(0);
  endtask

  task automatic reset1();
    rst1 = 1'b1;
    drive1();
    repeat (2) @(posedge clk);
    #1 rst1 = 1'b0;
    drive1();
  endtask

  // Sample n holds the registered outputs produced from raster cycle n.
  task automatic run0(input int ncyc);
    bit popped;
    resync_cnt = 0;
    for (int n = 0; n < ncyc; n++) begin
      @(negedge clk);
      popped = qi0.queue_rd_en && !qi0.queue_empty;
      @(posedge clk);
      #1;
      if (popped) q0.delete(0);
      drive0(n + 1);
      de_obs[n] = de0;
      hs_obs[n] = hs0;
      vs_obs[n] = vs0;
      px_obs[n] = {8'h00, r0, g0, b0};
      if (rsy0) resync_cnt++;
    end
  endtask

  task automatic run1(input int ncyc);
    bit popped;
    for (int n = 0; n < ncyc; n++) begin
      @(negedge clk);
      popped = qi1.queue_rd_en && !qi1.queue_empty;
      @(posedge clk);
      #1;
      if (popped) q1.delete(0);
      drive1();
      de_obs[n] = de1;
      hs_obs[n] = hs1;
      vs_obs[n] = vs1;
      px_obs[n] = {r1, g1, b1};
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    q0 = {};
    q0.push_back(17'h0_1234);
    rst0 = 1'b1;
    drive0(0);
    rst1 = 1'b1;
    drive1();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({de0, hs0, vs0, r0, g0, b0, uf0, rsy0} !== 35'h0) begin
      $display("FAIL reset0_outputs got de=%b hs=%b vs=%b rgb=%h uf=%h rs=%b, want all 0",
               de0, hs0, vs0, {r0, g0, b0}, uf0, rsy0);
    end else passed++;
    total++;
    if ({de1, hs1, vs1, r1, g1, b1, uf1, rsy1} !== {1'b0, 1'b1, 1'b1, 24'h0, 16'h0, 1'b0}) begin
      $display("FAIL reset1_outputs got de=%b hs=%b vs=%b rgb=%h uf=%h rs=%b, want de=0 hs=1 vs=1 rest 0",
               de1, hs1, vs1, {r1, g1, b1}, uf1, rsy1);
    end else passed++;
    @(negedge clk);
    total++;
    if (qi0.queue_rd_en !== 1'b0) begin
      $display("FAIL reset_no_pop rd_en=%b while in reset with a queued word, want 0", qi0.queue_rd_en);
    end else passed++;
    total++;
    if (qclk0 !== clk) begin
      $display("FAIL queue_clk got %b, want clk=%b", qclk0, clk);
    end else passed++;
  endtask

  task automatic test_full_frame();
    gen_set(0, HA);
    q0 = {};
    q0.push_back({1'b1, 16'h0000});
    push_lines0(0, 0, VA - 1);
    q0.push_back({1'b1, 16'hFFFF});
    stall_lo = -1;
    stall_hi = -1;
    clear_exp();
    for (int l = 0; l < VA; l++) place(0, 1, l, 1'b0);
    reset0();
    run0(3 * FRAME);
    for (int n = 0; n < 3 * FRAME; n++) begin
      logic [23:0] want = act_at(n) ? {8'h00, exp0[n]} : 24'h0;
      total++;
      if (de_obs[n] !== act_at(n) || hs_obs[n] !== hs_at(n) || vs_obs[n] !== vs_at(n) || px_obs[n] !== want) begin
        $display("FAIL full_frame n=%0d de/hs/vs=%b%b%b px=%h, want %b%b%b px=%h",
                 n, de_obs[n], hs_obs[n], vs_obs[n], px_obs[n], act_at(n), hs_at(n), vs_at(n), want);
      end else passed++;
    end
    total++;
    if (uf0 !== 16'd0) $display("FAIL full_frame_underflow got %0d, want 0", uf0);
    else passed++;
    total++;
    if (resync_cnt != 0) $display("FAIL full_frame_resync got %0d pulses, want 0", resync_cnt);
    else passed++;
  endtask

  task automatic test_underflow();
    gen_set(0, HA);
    q0 = {};
    q0.push_back({1'b1, 16'h0000});
    push_lines0(0, 0, VA - 1);
    q0.push_back({1'b1, 16'hFFFF});
    stall_lo = slot(1, 2, 3);
    stall_hi = slot(1, 2, 5);
    clear_exp();
    for (int l = 0; l < VA; l++) place(0, 1, l, 1'b0);
    reset0();
    run0(2 * FRAME);
    for (int n = FRAME; n < 2 * FRAME; n++) begin
      logic [23:0] want = act_at(n) ? {8'h00, exp0[n]} : 24'h0;
      total++;
      if (de_obs[n] !== act_at(n) || px_obs[n] !== want) begin
        $display("FAIL underflow n=%0d de=%b px=%h, want de=%b px=%h",
                 n, de_obs[n], px_obs[n], act_at(n), want);
      end else passed++;
    end
    total++;
    if (uf0 !== 16'd3) $display("FAIL underflow_count got %0d, want 3", uf0);
    else passed++;
    stall_lo = -1;
    stall_hi = -1;
  endtask

  task automatic test_overlong_line();
    gen_set(0, HA + 2);
    q0 = {};
    q0.push_back({1'b1, 16'h0000});
    push_lines0(0, 0, VA - 1);
    q0.push_back({1'b1, 16'hFFFF});
    clear_exp();
    for (int l = 0; l < VA; l++) place(0, 1, l, 1'b0);
    reset0();
    run0(2 * FRAME);
    for (int n = FRAME; n < 2 * FRAME; n++) begin
      logic [23:0] want = act_at(n) ? {8'h00, exp0[n]} : 24'h0;
      total++;
      if (de_obs[n] !== act_at(n) || px_obs[n] !== want) begin
        $display("FAIL overlong_line n=%0d de=%b px=%h, want de=%b px=%h",
                 n, de_obs[n], px_obs[n], act_at(n), want);
      end else passed++;
    end
    total++;
    if (q0.size() != 0) $display("FAIL overlong_drain %0d words left in queue, want 0", q0.size());
    else passed++;
    total++;
    if (uf0 !== 16'd0) $display("FAIL overlong_underflow got %0d, want 0", uf0);
    else passed++;
  endtask

  task automatic test_resync();
    gen_set(0, HA);
    gen_set(4, HA);
    q0 = {};
    q0.push_back({1'b1, 16'h0000});
    push_lines0(0, 0, 1);
    q0.push_back({1'b1, 16'h0000});
    push_lines0(4, 0, VA - 1);
    q0.push_back({1'b1, 16'hFFFF});
    clear_exp();
    place(0, 1, 0, 1'b0);
    place(0, 1, 1, 1'b0);
    for (int l = 0; l < VA; l++) place(4, 2, l, 1'b0);
    reset0();
    run0(4 * FRAME);
    for (int n = FRAME; n < 4 * FRAME; n++) begin
      logic [23:0] want = act_at(n) ? {8'h00, exp0[n]} : 24'h0;
      total++;
      if (de_obs[n] !== act_at(n) || px_obs[n] !== want) begin
        $display("FAIL resync n=%0d de=%b px=%h, want de=%b px=%h",
                 n, de_obs[n], px_obs[n], act_at(n), want);
      end else passed++;
    end
    total++;
    if (resync_cnt != 1) $display("FAIL resync_pulses got %0d, want 1", resync_cnt);
    else passed++;
  endtask

  task automatic test_888_polarity_reset();
    int ncyc = slot(1, 1, 3) + 1;
    logic [24:0] w;
    gen_set(0, HA);
    pix_set[0][0] = 24'hA5C37E;
    q1 = {};
    q1.push_back({1'b1, 24'h000000});
    for (int l = 0; l < VA; l++) begin
      q1.push_back({1'b1, 24'h000001});
      for (int k = 0; k < HA; k++) begin
        w = {1'b0, pix_set[l][k]};
        q1.push_back(w);
      end
    end
    q1.push_back({1'b1, 24'hFFFFFF});
    clear_exp();
    for (int l = 0; l < VA; l++) place(0, 1, l, 1'b1);
    reset1();
    run1(ncyc);
    for (int n = 0; n < ncyc; n++) begin
      logic [23:0] want = act_at(n) ? exp1[n] : 24'h0;
      total++;
      if (de_obs[n] !== act_at(n) || hs_obs[n] !== !hs_at(n) || vs_obs[n] !== !vs_at(n) || px_obs[n] !== want) begin
        $display("FAIL rgb888 n=%0d de/hs/vs=%b%b%b px=%h, want %b%b%b px=%h",
                 n, de_obs[n], hs_obs[n], vs_obs[n], px_obs[n], act_at(n), !hs_at(n), !vs_at(n), want);
      end else passed++;
    end
    total++;
    if (px_obs[slot(1, 0, 0)] !== 24'hA5C37E)
      $display("FAIL rgb888_unpack got R=%h G=%h B=%h, want R=A5 G=C3 B=7E",
               px_obs[slot(1, 0, 0)][23:16], px_obs[slot(1, 0, 0)][15:8], px_obs[slot(1, 0, 0)][7:0]);
    else passed++;
    // mid-line reset: the DUT is in the active window with pixels queued
    rst1 = 1'b1;
    @(negedge clk);
    total++;
    if (qi1.queue_rd_en !== 1'b0) $display("FAIL midline_reset_pop rd_en=%b, want 0", qi1.queue_rd_en);
    else passed++;
    @(posedge clk);
    #1;
    total++;
    if ({de1, hs1, vs1, r1, g1, b1, uf1, rsy1} !== {1'b0, 1'b1, 1'b1, 24'h0, 16'h0, 1'b0}) begin
      $display("FAIL midline_reset got de=%b hs=%b vs=%b rgb=%h uf=%h rs=%b, want de=0 hs=1 vs=1 rest 0",
               de1, hs1, vs1, {r1, g1, b1}, uf1, rsy1);
    end else passed++;
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_underflow();
    test_overlong_line();
    test_resync();
    test_888_polarity_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
